// File: rtl/io_controller_if.sv
// CPU-side and external-side bus bundle for io_controller.
// The controller sits on the slave modport; the CPU/external agent drives the master side.
interface io_controller_if;
  logic       cpu_wr;
  logic [7:0] cpu_wdata;
  logic       cpu_rd;
  logic [7:0] cpu_rdata;
  logic       out_full;
  logic       in_empty;
  logic       err_ovf;
  logic       err_udf;
  logic [7:0] ext_out_data;
  logic       ext_out_valid;
  logic       ext_out_ready;
  logic [7:0] ext_in_data;
  logic       ext_in_valid;
  logic       ext_in_ready;

  modport master (
    output cpu_wr, cpu_wdata, cpu_rd,
    output ext_out_ready, ext_in_data, ext_in_valid,
    input  cpu_rdata, out_full, in_empty,
    input  err_ovf, err_udf,
    input  ext_out_data, ext_out_valid, ext_in_ready
  );

  modport slave (
    input  cpu_wr, cpu_wdata, cpu_rd,
    input  ext_out_ready, ext_in_data, ext_in_valid,
    output cpu_rdata, out_full, in_empty,
    output err_ovf, err_udf,
    output ext_out_data, ext_out_valid, ext_in_ready
  );
endinterface

// File: rtl/io_controller.sv
// Byte I/O controller: two 4-deep FIFOs between a CPU port and
// an external valid/ready port, with sticky overflow/underflow flags.
module io_controller (
  input logic      clock,
  input logic      reset,
  io_controller_if.slave bus
);

  localparam logic [2:0] Depth = 3'd4;

  logic [7:0] out_mem_q [4];
  logic [1:0] out_wp_q, out_wp_d;
  logic [1:0] out_rp_q, out_rp_d;
  logic [2:0] out_cnt_q, out_cnt_d;

  logic [7:0] in_mem_q [4];
  logic [1:0] in_wp_q, in_wp_d;
  logic [1:0] in_rp_q, in_rp_d;
  logic [2:0] in_cnt_q, in_cnt_d;

  logic [7:0] rdata_q, rdata_d;
  logic       ovf_q, ovf_d;
  logic       udf_q, udf_d;

  logic out_push, out_pop;
  logic in_push, in_pop;

  assign out_push = bus.cpu_wr && (out_cnt_q != Depth);
  assign out_pop  = (out_cnt_q != 3'd0) && bus.ext_out_ready;
  assign in_push  = bus.ext_in_valid && (in_cnt_q != Depth);
  assign in_pop   = bus.cpu_rd && (in_cnt_q != 3'd0);

  always_comb begin
    out_wp_d  = out_wp_q;
    out_rp_d  = out_rp_q;
    out_cnt_d = out_cnt_q;
    in_wp_d   = in_wp_q;
    in_rp_d   = in_rp_q;
    in_cnt_d  = in_cnt_q;
    rdata_d   = rdata_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;

    if (out_push) out_wp_d = out_wp_q + 2'd1;
    if (out_pop)  out_rp_d = out_rp_q + 2'd1;
    out_cnt_d = out_cnt_q + {2'b00, out_push}
                          - {2'b00, out_pop};
    if (bus.cpu_wr && !out_push) ovf_d = 1'b1;

    if (in_push) in_wp_d = in_wp_q + 2'd1;
    if (in_pop)  in_rp_d = in_rp_q + 2'd1;
    in_cnt_d = in_cnt_q + {2'b00, in_push}
                        - {2'b00, in_pop};

    // An empty read returns zero and flags, but never blocks a push.
    if (in_pop) begin
      rdata_d = in_mem_q[in_rp_q];
    end else if (bus.cpu_rd) begin
      rdata_d = 8'h00;
      udf_d   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_wp_q  <= '0;
      out_rp_q  <= '0;
      out_cnt_q <= '0;
      in_wp_q   <= '0;
      in_rp_q   <= '0;
      in_cnt_q  <= '0;
      rdata_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      out_wp_q  <= out_wp_d;
      out_rp_q  <= out_rp_d;
      out_cnt_q <= out_cnt_d;
      in_wp_q   <= in_wp_d;
      in_rp_q   <= in_rp_d;
      in_cnt_q  <= in_cnt_d;
      rdata_q   <= rdata_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // Storage is left uncleared; zero counts hide stale bytes.
  always_ff @(posedge clock) begin
    if (!reset && out_push) out_mem_q[out_wp_q] <= bus.cpu_wdata;
    if (!reset && in_push)  in_mem_q[in_wp_q]   <= bus.ext_in_data;
  end

  assign bus.ext_out_data  = out_mem_q[out_rp_q];
  assign bus.ext_out_valid = (out_cnt_q != 3'd0);
  assign bus.out_full      = (out_cnt_q == Depth);
  assign bus.ext_in_ready  = (in_cnt_q != Depth);
  assign bus.in_empty      = (in_cnt_q == 3'd0);
  assign bus.cpu_rdata     = rdata_q;
  assign bus.err_ovf       = ovf_q;
  assign bus.err_udf       = udf_q;

endmodule

// File: tb/tb_io_controller.sv
// Directed-vector bench for io_controller.
// Inputs change #1 after each rising edge; outputs are sampled there too.
module tb_io_controller;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  logic [7:0] q [$];
  logic [7:0] exp_b;

  io_controller_if bus ();

  io_controller u_dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cpu_wr       = 1'b0;
    bus.cpu_wdata    = 8'h00;
    bus.cpu_rd       = 1'b0;
    bus.ext_in_valid = 1'b0;
    bus.ext_in_data  = 8'h00;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    idle();
    bus.ext_out_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;

    check("rst_oval",  8'(bus.ext_out_valid), 8'd0);
    check("rst_full",  8'(bus.out_full),      8'd0);
    check("rst_empty", 8'(bus.in_empty),      8'd1);
    check("rst_irdy",  8'(bus.ext_in_ready),  8'd1);
    check("rst_rdata", bus.cpu_rdata,         8'h00);
    check("rst_ovf",   8'(bus.err_ovf),       8'd0);
    check("rst_udf",   8'(bus.err_udf),       8'd0);

    // Three writes held back, then drained in order
    bus.cpu_wr = 1'b1;
    bus.cpu_wdata = 8'h11; cyc();
    bus.cpu_wdata = 8'h22; cyc();
    bus.cpu_wdata = 8'h33; cyc();
    idle();
    check("s1_valid", 8'(bus.ext_out_valid), 8'd1);
    check("s1_head",  bus.ext_out_data,      8'h11);
    cyc();
    check("s1_hold", bus.ext_out_data, 8'h11);
    bus.ext_out_ready = 1'b1;
    check("s1_d0", bus.ext_out_data, 8'h11); cyc();
    check("s1_d1", bus.ext_out_data, 8'h22); cyc();
    check("s1_d2", bus.ext_out_data, 8'h33); cyc();
    check("s1_gone", 8'(bus.ext_out_valid), 8'd0);
    bus.ext_out_ready = 1'b0;

    // Overfill the output FIFO
    bus.cpu_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.cpu_wdata = 8'hA0 + 8'(i);
      cyc();
    end
    check("s2_full4", 8'(bus.out_full), 8'd1);
    check("s2_ovf0",  8'(bus.err_ovf),  8'd0);
    bus.cpu_wdata = 8'hA4;
    cyc();
    idle();
    check("s2_ovf1",  8'(bus.err_ovf),  8'd1);
    check("s2_full5", 8'(bus.out_full), 8'd1);
    bus.ext_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'hA0 + 8'(i);
      check("s2_vld", 8'(bus.ext_out_valid), 8'd1);
      check("s2_drain", bus.ext_out_data, exp_b);
      cyc();
    end
    check("s2_gone",   8'(bus.ext_out_valid), 8'd0);
    check("s2_sticky", 8'(bus.err_ovf),       8'd1);
    bus.ext_out_ready = 1'b0;

    // Single input byte read back
    bus.ext_in_valid = 1'b1;
    bus.ext_in_data  = 8'h5A;
    cyc();
    idle();
    check("s3_nempty", 8'(bus.in_empty), 8'd0);
    bus.cpu_rd = 1'b1;
    cyc();
    idle();
    check("s3_rdata", bus.cpu_rdata,    8'h5A);
    check("s3_empty", 8'(bus.in_empty), 8'd1);
    cyc();
    check("s3_hold", bus.cpu_rdata, 8'h5A);

    // Underflow read with a concurrent push
    bus.cpu_rd       = 1'b1;
    bus.ext_in_valid = 1'b1;
    bus.ext_in_data  = 8'h7E;
    cyc();
    idle();
    check("s4_zero",   bus.cpu_rdata,       8'h00);
    check("s4_udf",    8'(bus.err_udf),     8'd1);
    check("s4_stored", 8'(bus.in_empty),    8'd0);
    bus.cpu_rd = 1'b1;
    cyc();
    idle();
    check("s4_rdata", bus.cpu_rdata,    8'h7E);
    check("s4_empty", 8'(bus.in_empty), 8'd1);

    // Fill, then interleave to wrap the input pointers
    q.delete();
    bus.ext_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ext_in_data = 8'hB0 + 8'(i);
      q.push_back(bus.ext_in_data);
      cyc();
    end
    check("s5_nrdy", 8'(bus.ext_in_ready), 8'd0);
    // Full: the offered byte must be refused while the pop proceeds
    bus.ext_in_data = 8'hEE;
    bus.cpu_rd = 1'b1;
    exp_b = q.pop_front();
    cyc();
    check("s5_pop0", bus.cpu_rdata, exp_b);
    check("s5_rdy", 8'(bus.ext_in_ready), 8'd1);
    for (int i = 0; i < 6; i++) begin
      bus.ext_in_data = 8'hC0 + 8'(i);
      exp_b = q.pop_front();
      q.push_back(bus.ext_in_data);
      cyc();
      check("s5_ilv", bus.cpu_rdata, exp_b);
    end
    idle();
    check("s5_rdy3", 8'(bus.ext_in_ready), 8'd1);
    bus.cpu_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_b = q.pop_front();
      cyc();
      check("s5_drain", bus.cpu_rdata, exp_b);
    end
    idle();
    check("s5_empty", 8'(bus.in_empty), 8'd1);
    check("s5_udf",   8'(bus.err_udf),  8'd1);

    // Concurrent CPU write and read
    bus.ext_in_valid = 1'b1;
    bus.ext_in_data  = 8'h3C;
    cyc();
    idle();
    bus.cpu_wr    = 1'b1;
    bus.cpu_wdata = 8'h96;
    bus.cpu_rd    = 1'b1;
    cyc();
    idle();
    check("s7_rd",   bus.cpu_rdata,    8'h3C);
    check("s7_wr",   bus.ext_out_data, 8'h96);
    check("s7_wvld", 8'(bus.ext_out_valid), 8'd1);

    // Reset with output traffic in flight
    bus.cpu_wr = 1'b1;
    bus.cpu_wdata = 8'hD0; cyc();
    bus.cpu_wdata = 8'hD1; cyc();
    idle();
    bus.ext_in_valid = 1'b1;
    bus.ext_in_data  = 8'h44;
    cyc();
    idle();
    check("s6_pend", 8'(bus.ext_out_valid), 8'd1);
    bus.ext_out_ready = 1'b1;
    bus.cpu_rd = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle();
    check("s6_oval",  8'(bus.ext_out_valid), 8'd0);
    check("s6_ovf",   8'(bus.err_ovf),       8'd0);
    check("s6_udf",   8'(bus.err_udf),       8'd0);
    check("s6_rdata", bus.cpu_rdata,         8'h00);
    check("s6_empty", 8'(bus.in_empty),      8'd1);
    check("s6_full",  8'(bus.out_full),      8'd0);
    cyc();
    check("s6_still", 8'(bus.ext_out_valid), 8'd0);
    bus.ext_out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
